multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle FSM sequencing the RV32I-subset datapath (R-type, I-type ALU, LW, SW, BEQ).
//  Decodes instr and drives PCSrc/ALUSrc/RegWrite/MemToReg/ALUCtrl/loadPC plus data-memory strobes.
//  Waits on a data-memory ready handshake; flags illegal opcodes and memory timeouts.
//  Sits beside the datapath in the CPU top; loadPC pulses exactly once per retired/aborted instr.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in MEM waiting for dReady before abort (>=2)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  instr        in   32  current instruction (stable from IF until loadPC edge)
//  Zero         in   1   ALU zero flag from datapath
//  dReady       in   1   data memory done (read data valid / write accepted)
//  PCSrc        out  1   1: PC <= PC+immB on loadPC; 0: PC+4
//  ALUSrc       out  1   1: ALU op2 = immediate
//  RegWrite     out  1   register-file write enable
//  MemToReg     out  1   1: writeback from dReadData
//  ALUCtrl      out  4   ALU operation
//  loadPC       out  1   PC update enable (one-cycle pulse)
//  MemRead      out  1   data-memory read request
//  MemWrite     out  1   data-memory write request
//  state_o      out  3   current state (debug)
//  err_illegal  out  1   sticky: illegal opcode/funct seen
//  err_timeout  out  1   sticky: MEM timeout occurred
// BEHAVIOUR
//  Reset (async): state=IF, all outputs 0, timeout counter 0, sticky flags cleared.
//  States: IF=0, ID=1, EX=2, MEM=3, WB=4. Outputs are decodes of state + opcode/funct latched in IF.
//  IF: latch instr[6:0], funct3, instr[30] -> ID.
//  ID: opcode legal -> EX. Illegal (opcode not 0110011/0010011/0000011/0100011/1100011, or
//   R-type funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101) -> loadPC=1, PCSrc=0,
//   err_illegal<=1, -> IF.
//  ALUCtrl: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000.
//   R/I: funct3 000 ADD (R with instr[30]: SUB; I-type ADDI ignores instr[30]), 001 SLL,
//   010 SLT, 100 XOR, 101 SRL/SRA by instr[30], 110 OR, 111 AND. Unlisted funct3 (011) -> illegal.
//   LW/SW: ADD. BEQ: SUB. ALUCtrl held constant from EX through end of instr; 0 in IF/ID.
//  ALUSrc=1 for I-type, LW, SW in EX/MEM/WB; 0 otherwise.
//  EX: R/I -> WB. LW/SW -> MEM (counter cleared). BEQ: loadPC=1, PCSrc=Zero, -> IF.
//  MEM: LW MemRead=1, SW MemWrite=1, held until dReady or timeout.
//   dReady=1: LW -> WB; SW -> loadPC=1, -> IF. Counter increments each MEM cycle without dReady;
//   at count==MEM_TIMEOUT-1 with dReady=0: strobes drop, loadPC=1, PCSrc=0, err_timeout<=1, -> IF,
//   no register write. dReady on the timeout cycle wins (normal completion).
//  WB: RegWrite=1, loadPC=1, PCSrc=0; MemToReg=1 only for LW. -> IF.
//  PCSrc is 0 whenever loadPC is 0. RegWrite/MemRead/MemWrite never asserted outside listed states.
//  CPI: BEQ 3, R/I 4, SW 4+wait, LW 5+wait (wait = cycles of dReady=0 in MEM).
//  rst mid-instruction: immediate return to IF, strobes drop asynchronously, no partial write.
//  dReady ignored outside MEM. Sticky flags cleared only by rst.
// TESTING
//  ADD x3,x1,x2 (0x002081B3): states IF,ID,EX,WB; ALUCtrl=0010, ALUSrc=0; RegWrite+loadPC in cycle 4 only.
//  BEQ with Zero=1 / Zero=0: cycle 3 loadPC=1, PCSrc=1 / PCSrc=0; ALUCtrl=0110; no RegWrite.
//  LW, dReady after 3 MEM cycles: MemRead high 3 cycles, then WB with MemToReg=1, RegWrite=1, loadPC=1.
//  SW, dReady=0 forever, MEM_TIMEOUT=16: MemWrite high 16 cycles, loadPC=1, err_timeout=1, next state IF.
//  instr=0xFFFFFFFF: ID asserts loadPC=1, PCSrc=0, err_illegal=1; no RegWrite/MemWrite ever.
//  rst pulsed mid-MEM of LW: outputs 0 same cycle, state_o=0, flags cleared, normal fetch after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I-subset datapath (R-type, I-type ALU, LW, SW, BEQ).
// State, latched instruction fields, MEM wait counter and sticky error flags are registered;
// datapath controls are decoded from the current state and latched fields so that loadPC,
// PCSrc and the MEM-exit decision can respond to Zero/dReady within the same cycle.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dReady,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  state_o,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSll = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSrl = 4'b0101;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSra = 4'b1000;

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      funct7_q, funct7_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_timeout_q, err_timeout_d;

  logic            illegal;
  logic [3:0]      alu_op;
  logic            is_lw, is_sw;

  assign is_lw = (opcode_q == OpLw);
  assign is_sw = (opcode_q == OpSw);

  // Legality check of the latched opcode/funct fields.
  always_comb begin
    illegal = 1'b0;
    case (opcode_q)
      OpR: begin
        if (funct3_q == 3'b011) begin
          illegal = 1'b1;
        end else if (funct7_q == 7'b0100000) begin
          illegal = !((funct3_q == 3'b000) || (funct3_q == 3'b101));
        end else if (funct7_q != 7'b0000000) begin
          illegal = 1'b1;
        end
      end
      OpI:               illegal = (funct3_q == 3'b011);
      OpLw, OpSw, OpBeq: illegal = 1'b0;
      default:           illegal = 1'b1;
    endcase
  end

  // ALU operation for the latched instruction; instr[30] only selects SUB for R-type ADD.
  always_comb begin
    alu_op = AluAdd;
    case (opcode_q)
      OpR, OpI: begin
        case (funct3_q)
          3'b000:  alu_op = ((opcode_q == OpR) && funct7_q[5]) ? AluSub : AluAdd;
          3'b001:  alu_op = AluSll;
          3'b010:  alu_op = AluSlt;
          3'b100:  alu_op = AluXor;
          3'b101:  alu_op = funct7_q[5] ? AluSra : AluSrl;
          3'b110:  alu_op = AluOr;
          3'b111:  alu_op = AluAnd;
          default: alu_op = AluAdd;
        endcase
      end
      OpBeq:   alu_op = AluSub;
      default: alu_op = AluAdd;
    endcase
  end

  // Next-state logic and control decode.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct3_d      = funct3_q;
    funct7_d      = funct7_q;
    cnt_d         = cnt_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    PCSrc         = 1'b0;
    ALUSrc        = 1'b0;
    RegWrite      = 1'b0;
    MemToReg      = 1'b0;
    ALUCtrl       = 4'b0000;
    loadPC        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;

    if ((state_q == StEx) || (state_q == StMem) || (state_q == StWb)) begin
      ALUCtrl = alu_op;
      ALUSrc  = (opcode_q == OpI) || is_lw || is_sw;
    end

    case (state_q)
      StIf: begin
        opcode_d = instr[6:0];
        funct3_d = instr[14:12];
        funct7_d = instr[31:25];
        state_d  = StId;
      end
      StId: begin
        if (illegal) begin
          loadPC        = 1'b1;
          err_illegal_d = 1'b1;
          state_d       = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        if (opcode_q == OpBeq) begin
          loadPC  = 1'b1;
          PCSrc   = Zero;
          state_d = StIf;
        end else if (is_lw || is_sw) begin
          cnt_d   = '0;
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // Strobes stay up through the final wait cycle so a late dReady still completes.
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (dReady) begin
          if (is_lw) begin
            state_d = StWb;
          end else begin
            loadPC  = 1'b1;
            state_d = StIf;
          end
        end else if (cnt_q == CntLast) begin
          loadPC        = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = StIf;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        MemToReg = is_lw;
        loadPC   = 1'b1;
        state_d  = StIf;
      end
      default: state_d = StIf;
    endcase
  end

  // State, latched fields, wait counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIf;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_q      <= '0;
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct3_q      <= funct3_d;
      funct7_q      <= funct7_d;
      cnt_q         <= cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign state_o     = state_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is run to its loadPC pulse while the bench tallies
// what it saw, and the tallies are compared with a per-instruction-class model (state trace,
// strobe cycle counts, ALU op, PC select, sticky flags).
module tb_multicycle_ctrl;

  localparam int T = 16;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SLL = 4'b0011;
  localparam logic [3:0] A_XOR = 4'b0100;
  localparam logic [3:0] A_SRL = 4'b0101;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_SRA = 4'b1000;

  typedef enum int {KR, KI, KLw, KSw, KBeq, KIll} kind_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        Zero = 1'b0;
  logic        dReady = 1'b0;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state_o;
  logic        err_illegal, err_timeout;

  int tests = 0;
  int fails = 0;
  logic exp_ill = 1'b0;
  logic exp_to  = 1'b0;

  multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .Zero       (Zero),
    .dReady     (dReady),
    .PCSrc      (PCSrc),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .MemToReg   (MemToReg),
    .ALUCtrl    (ALUCtrl),
    .loadPC     (loadPC),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .state_o    (state_o),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic kind_e kind_of(input logic [31:0] ins);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (op)
      7'h33: begin
        if (f3 == 3'd3) return KIll;
        if (f7 == 7'h00) return KR;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return KR;
        return KIll;
      end
      7'h13:   return (f3 == 3'd3) ? KIll : KI;
      7'h03:   return KLw;
      7'h23:   return KSw;
      7'h63:   return KBeq;
      default: return KIll;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] ins, input kind_e k);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (k == KLw || k == KSw) return A_ADD;
    if (k == KBeq) return A_SUB;
    if (k == KIll) return 4'b0000;
    case (f3)
      3'd0:    return (k == KR && ins[30]) ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd4:    return A_XOR;
      3'd5:    return ins[30] ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
  endfunction

  function automatic logic [31:0] mk_i(input logic [2:0] f3, input logic b30);
    logic [31:0] w;
    w = {12'($urandom), 5'($urandom), f3, 5'($urandom), 7'h13};
    w[30] = b30;
    return w;
  endfunction

  function automatic logic [31:0] mk_op(input logic [6:0] op);
    return {25'($urandom), op};
  endfunction

  // Runs one instruction from IF to its loadPC pulse; w = MEM cycles with dReady low.
  task automatic run_instr(input logic [31:0] ins, input logic zero, input int w, input string tag);
    kind_e k;
    logic [3:0] ealu;
    logic esrc, erw, em2r, epc, tmo, done, pc_at_load, trace_ok;
    int mem_n, cyc, mem_seen, rw_cnt, rd_cnt, wr_cnt, alu_bad, src_bad, m2r_bad, pc_bad, rw_bad;
    int exp_st[$];
    int obs_st[$];
    k     = kind_of(ins);
    ealu  = alu_of(ins, k);
    esrc  = (k == KI || k == KLw || k == KSw);
    tmo   = (k == KLw || k == KSw) && (w >= T);
    mem_n = (k == KLw || k == KSw) ? (tmo ? T : w + 1) : 0;
    erw   = (k == KR || k == KI) || (k == KLw && !tmo);
    em2r  = (k == KLw && !tmo);
    epc   = (k == KBeq) ? zero : 1'b0;
    exp_st.push_back(0);
    exp_st.push_back(1);
    if (k != KIll) begin
      exp_st.push_back(2);
      repeat (mem_n) exp_st.push_back(3);
      if (erw) exp_st.push_back(4);
    end
    done = 1'b0; pc_at_load = 1'b0; cyc = 0; mem_seen = 0;
    rw_cnt = 0; rd_cnt = 0; wr_cnt = 0; alu_bad = 0; src_bad = 0; m2r_bad = 0; pc_bad = 0;
    rw_bad = 0;
    instr = ins;
    while (!done && cyc < 64) begin
      @(negedge clk);
      dReady = (state_o == 3'd3) ? (mem_seen == w) : 1'($urandom);
      Zero   = (state_o == 3'd2) ? zero : 1'($urandom);
      #1;
      obs_st.push_back(int'(state_o));
      if (state_o == 3'd3) mem_seen++;
      if (RegWrite) begin
        rw_cnt++;
        if (!loadPC) rw_bad++;
        if (MemToReg !== em2r) m2r_bad++;
      end else if (MemToReg) begin
        m2r_bad++;
      end
      if (MemRead) rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (cyc < 2) begin
        if (ALUCtrl !== 4'b0000) alu_bad++;
        if (ALUSrc !== 1'b0) src_bad++;
      end else begin
        if (ALUCtrl !== ealu) alu_bad++;
        if (ALUSrc !== esrc) src_bad++;
      end
      if (!loadPC && PCSrc) pc_bad++;
      if (loadPC) begin
        done = 1'b1;
        pc_at_load = PCSrc;
      end
      cyc++;
      @(posedge clk);
    end
    #1;
    exp_ill = exp_ill | (k == KIll);
    exp_to  = exp_to | tmo;

    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s loadPC: never pulsed within 64 cycles, required a pulse", tag);
    end
    trace_ok = (obs_st.size() == exp_st.size());
    if (trace_ok) foreach (exp_st[i]) if (obs_st[i] != exp_st[i]) trace_ok = 1'b0;
    tests++;
    if (!trace_ok) begin
      fails++;
      $display("FAIL %s state trace: got %p, required %p", tag, obs_st, exp_st);
    end
    tests++;
    if (rw_cnt != (erw ? 1 : 0) || rw_bad != 0) begin
      fails++;
      $display("FAIL %s RegWrite: got %0d cycles (%0d off loadPC), required %0d", tag, rw_cnt,
               rw_bad, erw ? 1 : 0);
    end
    tests++;
    if (rd_cnt != ((k == KLw) ? mem_n : 0) || wr_cnt != ((k == KSw) ? mem_n : 0)) begin
      fails++;
      $display("FAIL %s mem strobes: got rd=%0d wr=%0d, required rd=%0d wr=%0d", tag, rd_cnt,
               wr_cnt, (k == KLw) ? mem_n : 0, (k == KSw) ? mem_n : 0);
    end
    tests++;
    if (alu_bad != 0 || src_bad != 0) begin
      fails++;
      $display("FAIL %s ALUCtrl/ALUSrc: got %0d/%0d bad cycles, required 0 (op %b src %b)", tag,
               alu_bad, src_bad, ealu, esrc);
    end
    tests++;
    if (pc_at_load !== epc || pc_bad != 0) begin
      fails++;
      $display("FAIL %s PCSrc: got %b at loadPC (%0d stray), required %b", tag, pc_at_load,
               pc_bad, epc);
    end
    tests++;
    if (m2r_bad != 0) begin
      fails++;
      $display("FAIL %s MemToReg: got %0d bad cycles, required 0", tag, m2r_bad);
    end
    tests++;
    if (err_illegal !== exp_ill || err_timeout !== exp_to) begin
      fails++;
      $display("FAIL %s flags: got ill=%b to=%b, required ill=%b to=%b", tag, err_illegal,
               err_timeout, exp_ill, exp_to);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    dReady = 1'b1;
    Zero = 1'b1;
    instr = 32'h002081B3;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite} !== 11'd0 ||
        state_o !== 3'd0 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset: got state=%0d ctrl=%b flags=%b%b, required all zero", state_o,
               {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite},
               err_illegal, err_timeout);
    end
    rst = 1'b0;
    dReady = 1'b0;
  endtask

  task automatic test_add();
    run_instr(32'h002081B3, 1'b0, 0, "add");
    run_instr(mk_r(7'h20, 3'd0), 1'b1, 0, "sub");
    run_instr(mk_i(3'd0, 1'b1), 1'b0, 0, "addi_b30");
    run_instr(mk_i(3'd5, 1'b1), 1'b0, 0, "srai");
  endtask

  task automatic test_beq();
    run_instr(mk_op(7'h63), 1'b1, 0, "beq_taken");
    run_instr(mk_op(7'h63), 1'b0, 0, "beq_not_taken");
  endtask

  task automatic test_mem();
    run_instr(mk_op(7'h03), 1'b0, 2, "lw_wait2");
    run_instr(mk_op(7'h23), 1'b0, 0, "sw_nowait");
    run_instr(mk_op(7'h03), 1'b0, T - 1, "lw_ready_on_last");
    run_instr(mk_op(7'h23), 1'b0, T - 1, "sw_ready_on_last");
    run_instr(mk_op(7'h23), 1'b0, 1000, "sw_timeout");
    run_instr(mk_op(7'h03), 1'b0, T, "lw_timeout");
  endtask

  task automatic test_illegal();
    run_instr(32'hFFFFFFFF, 1'b0, 0, "ill_ones");
    run_instr(mk_r(7'h01, 3'd0), 1'b0, 0, "ill_funct7");
    run_instr(mk_r(7'h20, 3'd1), 1'b0, 0, "ill_sub_f3");
    run_instr(mk_i(3'd3, 1'b0), 1'b0, 0, "ill_i_f3");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int w;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0:       ins = mk_r(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h20, 3'($urandom));
        1:       ins = mk_r(7'h00, 3'($urandom));
        2:       ins = mk_i(3'($urandom), 1'($urandom));
        3:       ins = mk_op(7'h03);
        4:       ins = mk_op(7'h23);
        5:       ins = mk_op(7'h63);
        default: ins = 32'($urandom);
      endcase
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
      run_instr(ins, 1'($urandom), w, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    int guard;
    logic rd_before;
    instr = mk_op(7'h03);
    guard = 0;
    dReady = 1'b0;
    while (state_o !== 3'd3 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    rd_before = MemRead;
    rst = 1'b1;
    #1;
    tests++;
    if (rd_before !== 1'b1 || MemRead !== 1'b0 || state_o !== 3'd0 || loadPC !== 1'b0 ||
        RegWrite !== 1'b0 || ALUCtrl !== 4'd0 || err_illegal !== 1'b0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_mem: got rd_before=%b rd=%b state=%0d flags=%b%b, required 1 0 0 00",
               rd_before, MemRead, state_o, err_illegal, err_timeout);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ill = 1'b0;
    exp_to = 1'b0;
    run_instr(32'h002081B3, 1'b0, 0, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq();
    test_mem();
    test_illegal();
    test_random();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
